bit_scan_stream: RTL and testbench

BIT_SCAN_STREAM -- requirements
Module: bit_scan_stream

---
 rtl/bit_scan_stream.sv | 151 +++++++++++++++
 tb/tb_bit_scan_stream.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_scan_stream.sv
// bit_scan_stream: accepts one word at a time and streams out the index of
// every set bit, most significant first, one beat per output handshake.
// An all-zero word produces a single beat flagged empty.
//
// Optional feature: define BIT_SCAN_POPCOUNT_EN to add the out_count port,
// which carries the number of ones in the word for every beat of that word.
module bit_scan_stream #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_empty
`ifdef BIT_SCAN_POPCOUNT_EN
  ,
  output logic [IDX_W:0]   out_count
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Index of the highest set bit; 0 for an all-zero vector.
  function automatic logic [IDX_W-1:0] msb_idx(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) r = i[IDX_W-1:0];
    end
    return r;
  endfunction

  // True when exactly one bit of the vector is set.
  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] vm1;
    vm1 = v - {{(WIDTH-1){1'b0}}, 1'b1};
    return (v != '0) && ((v & vm1) == '0);
  endfunction

`ifdef BIT_SCAN_POPCOUNT_EN
  // Number of ones in the vector.
  function automatic logic [IDX_W:0] popcnt(input logic [WIDTH-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + {{IDX_W{1'b0}}, v[i]};
    end
    return c;
  endfunction
`endif

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] rem_p1;
  logic [WIDTH-1:0] clr_mask;
  logic [IDX_W-1:0] top_idx;
  logic             rem_zero;
  logic             rem_one;
  logic             final_beat;
  logic             vld_p1;
  logic             in_fire;
  logic             out_fire;

  // Decode the remaining-bits register: next index, and whether this beat ends the word.
  always_comb begin
    top_idx           = msb_idx(rem_p1);
    rem_zero          = (rem_p1 == '0);
    rem_one           = is_onehot(rem_p1);
    final_beat        = rem_zero | rem_one;
    clr_mask          = '0;
    clr_mask[top_idx] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and handshake flags; a zero word leaves after its single empty beat.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    vld_p1   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = EMIT;
      end
      EMIT: begin
        vld_p1 = 1'b1;
        if (out_ready && final_beat) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = vld_p1 & out_ready;

  // ---- stage p1: remaining bits of the word being emitted ----
  // Load on acceptance; drop the reported bit on each output handshake, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_p1 <= '0;
    end else if (in_fire) begin
      rem_p1 <= in_data;
    end else if (out_fire) begin
      rem_p1 <= rem_p1 & ~clr_mask;
    end
  end

  // Beat outputs are forced to zero whenever no beat is being presented.
  always_comb begin
    out_valid = vld_p1;
    out_idx   = vld_p1 ? top_idx : '0;
    out_last  = vld_p1 & final_beat;
    out_empty = vld_p1 & rem_zero;
  end

`ifdef BIT_SCAN_POPCOUNT_EN
  logic [IDX_W:0] cnt_p1;

  // Popcount is taken once from the accepted word and held for all of its beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1 <= '0;
    end else if (in_fire) begin
      cnt_p1 <= popcnt(in_data);
    end
  end

  // Count is only visible while a beat is presented.
  always_comb begin
    out_count = vld_p1 ? cnt_p1 : '0;
  end
`endif

endmodule

// File: tb/tb_bit_scan_stream.sv
// Scoreboard bench for bit_scan_stream (WIDTH=8). Stimulus pushes the
// hand-computed beats of each word into a queue; a monitor pops and compares
// on every output handshake. Count checks apply when BIT_SCAN_POPCOUNT_EN is set.
module tb_bit_scan_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       out_empty;
`ifdef BIT_SCAN_POPCOUNT_EN
  logic [3:0] out_count;
`endif

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
    logic       empty;
    logic [3:0] count;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  bit_scan_stream #(.WIDTH(8), .IDX_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_empty (out_empty)
`ifdef BIT_SCAN_POPCOUNT_EN
    ,
    .out_count (out_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_beat(input int idx, input bit last, input bit empty, input int cnt);
    beat_t b;
    b.idx   = idx[2:0];
    b.last  = last;
    b.empty = empty;
    b.count = cnt[3:0];
    exp_q.push_back(b);
  endtask

  // Present a word and hold it until the DUT accepts it (bounded).
  task automatic send(input logic [7:0] d);
    bit done;
    done     = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (in_ready === 1'b1) done = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  // Wait until all expected beats have been consumed, then check the block is idle.
  task automatic drain(input string name);
    bit done;
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) done = 1;
    end
    if (!done) check({name, "_drain_timeout"}, exp_q.size(), 0);
    else begin
      check({name, "_in_ready_after"}, int'(in_ready), 1);
      check({name, "_out_valid_after"}, int'(out_valid), 0);
    end
  endtask

  // Monitor: compare each accepted beat with the scoreboard, and check idle outputs.
  always @(negedge clk) begin
    beat_t e;
    if (rst === 1'b0) begin
      check("in_ready_vs_valid", int'(in_ready), int'(!out_valid));
      if (out_valid !== 1'b1) begin
        check("idle_idx", int'(out_idx), 0);
        check("idle_last", int'(out_last), 0);
        check("idle_empty", int'(out_empty), 0);
`ifdef BIT_SCAN_POPCOUNT_EN
        check("idle_count", int'(out_count), 0);
`endif
      end else if (out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat_idx", int'(out_idx), -1);
        end else begin
          e = exp_q.pop_front();
          check("beat_idx", int'(out_idx), int'(e.idx));
          check("beat_last", int'(out_last), int'(e.last));
          check("beat_empty", int'(out_empty), int'(e.empty));
`ifdef BIT_SCAN_POPCOUNT_EN
          check("beat_count", int'(out_count), int'(e.count));
`endif
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_idx", int'(out_idx), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_empty", int'(out_empty), 0);
`ifdef BIT_SCAN_POPCOUNT_EN
    check("rst_out_count", int'(out_count), 0);
`endif
    rst = 1'b0;

    // Zero word: one empty beat.
    push_beat(0, 1, 1, 0);
    send(8'b0000_0000);
    drain("zero");

    // All ones: 7 down to 0.
    for (int i = 7; i >= 0; i--) push_beat(i, (i == 0), 0, 8);
    send(8'b1111_1111);
    drain("ones");

    // Sparse word.
    push_beat(7, 0, 0, 3);
    push_beat(5, 0, 0, 3);
    push_beat(2, 1, 0, 3);
    send(8'b1010_0100);
    drain("sparse");

    // Single LSB.
    push_beat(0, 1, 0, 1);
    send(8'b0000_0001);
    drain("lsb");

    // Backpressure: idx 7 held through 4 stalled cycles.
    out_ready = 1'b0;
    push_beat(7, 0, 0, 3);
    push_beat(5, 0, 0, 3);
    push_beat(2, 1, 0, 3);
    send(8'b1010_0100);
    repeat (4) begin
      @(negedge clk);
      check("stall_valid", int'(out_valid), 1);
      check("stall_idx", int'(out_idx), 7);
      check("stall_last", int'(out_last), 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain("stall");

    // Reset after the first beat of 11110000 discards the rest.
    push_beat(7, 0, 0, 4);
    send(8'b1111_0000);
    begin
      bit done;
      done = 0;
      for (int c = 0; c < 50 && !done; c++) begin
        @(posedge clk);
        #2;
        if (exp_q.size() == 0) done = 1;
      end
      if (!done) check("rst_mid_timeout", exp_q.size(), 0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_in_ready", int'(in_ready), 1);
    check("rst_mid_out_valid", int'(out_valid), 0);
    check("rst_mid_out_idx", int'(out_idx), 0);
    push_beat(0, 1, 0, 1);
    send(8'b0000_0001);
    drain("after_rst");

    // Second word presented during EMIT waits; no interleaving.
    push_beat(7, 0, 0, 3);
    push_beat(5, 0, 0, 3);
    push_beat(2, 1, 0, 3);
    push_beat(7, 0, 0, 2);
    push_beat(0, 1, 0, 2);
    send(8'b1010_0100);
    send(8'b1000_0001);
    drain("b2b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
